// File: rtl/heap_sort_stream.sv
// Purpose: sorts one packed vector of N unsigned W-bit elements in a register-array
//          binary heap (max-heap for ascending, min-heap for descending), one vector at a time.
// Latency: data dependent; N=1 takes 1 cycle, N=7 takes at most 30 cycles from acceptance to out_valid.
// Backpressure: in_ready only in IDLE; result is held with out_valid high until out_ready, no data lost.
//
// Ports:
//   system1000 / system1000_rst : clock, synchronous active-high reset
//   in_valid / in_ready / in_vec / in_desc : input vector handshake, in_desc=1 sorts descending
//   out_valid / out_ready / out_vec        : sorted vector handshake, out_vec holds after handshake
//   busy        : high from acceptance until out_valid rises
//   sort_cycles : acceptance-to-out_valid cycle count of the last transaction (saturating)
module heap_sort_stream #(
    parameter int N  = 7,
    parameter int W  = 23,
    parameter int CW = 16
) (
    input  logic            system1000,
    input  logic            system1000_rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_vec,
    input  logic            in_desc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  out_vec,
    output logic            busy,
    output logic [CW-1:0]   sort_cycles
);

    localparam int IW = $clog2(N + 1);              // heap size / count width
    localparam int AW = (N > 1) ? $clog2(N) : 1;    // array index width
    localparam int XW = IW + 2;                     // room for 2k+2 without overflow
    localparam int BSTART = (N > 1) ? (N / 2 - 1) : 0;
    localparam logic [AW-1:0] BSTART_A = AW'(BSTART);
    localparam logic [IW-1:0] N_S      = IW'(N);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] BUILD   = 3'd1;
    localparam logic [2:0] EXTRACT = 3'd2;
    localparam logic [2:0] SIFT    = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [W-1:0]   a_q [N];
    logic [W-1:0]   a_d [N];
    logic [AW-1:0]  k_q, k_d;               // current sift node
    logic [IW-1:0]  s_q, s_d;               // current heap size
    logic [AW-1:0]  kb_q, kb_d;             // next build node
    logic           caller_build_q, caller_build_d;
    logic           desc_q, desc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           out_valid_q, out_valid_d;
    logic [N*W-1:0] out_vec_q, out_vec_d;
    logic [CW-1:0]  sort_cycles_q, sort_cycles_d;

    // "a beats b": greater for the ascending max-heap, smaller for the descending min-heap
    function automatic logic better(input logic [W-1:0] a, input logic [W-1:0] b, input logic d);
        return d ? (a < b) : (a > b);
    endfunction

    // One sift step at node k: pick the better in-range child and decide whether to swap
    logic [XW-1:0] l_w, r_w, s_w, cl_w;
    logic [AW-1:0] l_idx, r_idx, c_idx, last_idx;
    logic          l_ok, r_ok, pick_r, do_swap, c_leaf, sift_ret;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        s_w      = XW'(s_q);
        l_w      = (XW'(k_q) << 1) + XW'(1);
        r_w      = l_w + XW'(1);
        l_ok     = l_w < s_w;
        r_ok     = r_w < s_w;
        l_idx    = l_w[AW-1:0];
        r_idx    = r_w[AW-1:0];
        // ties between children resolve to the left one; either is a valid heap choice
        pick_r   = l_ok && r_ok && better(a_q[r_idx], a_q[l_idx], desc_q);
        c_idx    = pick_r ? r_idx : l_idx;
        // strict compare keeps the parent on ties
        do_swap  = l_ok && better(a_q[c_idx], a_q[k_q], desc_q);
        cl_w     = (XW'(c_idx) << 1) + XW'(1);
        // if the node we swap into has no children the sift ends in the same cycle
        c_leaf   = !(cl_w < s_w);
        last_idx = AW'(s_q - IW'(1));
        cnt_inc  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    end

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        k_d            = k_q;
        s_d            = s_q;
        kb_d           = kb_q;
        caller_build_d = caller_build_q;
        desc_d         = desc_q;
        cnt_d          = busy_q ? cnt_inc : cnt_q;
        busy_d         = busy_q;
        out_valid_d    = out_valid_q;
        out_vec_d      = out_vec_q;
        sort_cycles_d  = sort_cycles_q;
        sift_ret       = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < N; i++) begin
                        a_d[i] = in_vec[W*i +: W];
                    end
                    desc_d  = in_desc;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    kb_d    = BSTART_A;
                    s_d     = N_S;
                    state_d = (N > 1) ? BUILD : DONE;
                end
            end
            BUILD: begin
                k_d            = kb_q;
                s_d            = N_S;
                caller_build_d = 1'b1;
                state_d        = SIFT;
            end
            SIFT: begin
                if (do_swap) begin
                    a_d[k_q]   = a_q[c_idx];
                    a_d[c_idx] = a_q[k_q];
                    k_d        = c_idx;
                    sift_ret   = c_leaf;
                end else begin
                    sift_ret   = 1'b1;
                end
                if (sift_ret) begin
                    if (caller_build_q) begin
                        if (kb_q == '0) begin
                            state_d = EXTRACT;
                        end else begin
                            kb_d    = kb_q - AW'(1);
                            state_d = BUILD;
                        end
                    end else begin
                        state_d = EXTRACT;
                    end
                end
            end
            EXTRACT: begin
                // heap size is always >= 2 here; the final swap leaves a one-element heap
                a_d[0]         = a_q[last_idx];
                a_d[last_idx]  = a_q[0];
                s_d            = s_q - IW'(1);
                k_d            = '0;
                caller_build_d = 1'b0;
                state_d        = (s_q == IW'(2)) ? DONE : SIFT;
            end
            DONE: begin
                if (!out_valid_q) begin
                    // first DONE cycle: publish the result and close the cycle count
                    for (int i = 0; i < N; i++) begin
                        out_vec_d[W*i +: W] = a_q[i];
                    end
                    out_valid_d   = 1'b1;
                    busy_d        = 1'b0;
                    sort_cycles_d = cnt_inc;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_q        <= IDLE;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
            end
            k_q            <= '0;
            s_q            <= '0;
            kb_q           <= '0;
            caller_build_q <= 1'b0;
            desc_q         <= 1'b0;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_vec_q      <= '0;
            sort_cycles_q  <= '0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            k_q            <= k_d;
            s_q            <= s_d;
            kb_q           <= kb_d;
            caller_build_q <= caller_build_d;
            desc_q         <= desc_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            out_valid_q    <= out_valid_d;
            out_vec_q      <= out_vec_d;
            sort_cycles_q  <= sort_cycles_d;
        end
    end

    // all outputs come straight from registers: no in_valid->in_ready or out_ready->out_valid path
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign out_vec     = out_vec_q;
    assign busy        = busy_q;
    assign sort_cycles = sort_cycles_q;

endmodule
